// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean of a sorted window: sums the middle N samples,
// then divides by N with a bit-serial restoring divider.
module alpha_trim_mean #(
  parameter int DN          = 25,
  parameter int DW          = 8,
  parameter int DW_sequence = $clog2(DN),
  parameter int TRIM        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sort_finish,
  input  logic [DW*DN-1:0]          data_unsort,
  input  logic [DW_sequence*DN-1:0] sequence_sorted,
  output logic [DW-1:0]             mean_out,
  output logic                      mean_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int N    = DN - 2*TRIM;
  localparam int ACCW = DW + $clog2(DN);
  localparam int CW   = (DN > 1) ? $clog2(DN) : 1;
  localparam int DCW  = $clog2(ACCW + 1);
  localparam int RW   = ACCW + 1;

  localparam logic [RW-1:0]   DIVISOR = RW'(N);
  localparam logic [ACCW-1:0] ROUND   = ACCW'(N / 2);
  localparam logic [CW-1:0]   FIRST   = CW'(TRIM);
  localparam logic [CW-1:0]   LAST    = CW'(DN - 1 - TRIM);
  localparam logic [DCW-1:0]  DLAST   = DCW'(ACCW - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DIV
  } state_t;

  state_t state, state_nx;

  logic [DW*DN-1:0]          data_q;
  logic [DW_sequence*DN-1:0] seq_q;
  logic [CW-1:0]             cnt;
  logic [DCW-1:0]            dcnt;
  logic [ACCW-1:0]           acc;
  logic [ACCW-1:0]           rem;

  logic [DW_sequence-1:0]    idx;
  logic [DW-1:0]             sample;
  logic [RW-1:0]             rem_sh;
  logic [ACCW-1:0]           rem_nx;
  logic [ACCW-1:0]           q_nx;
  logic                      start;
  logic                      acc_done;
  logic                      div_done;

  // Out-of-range indices select nothing and contribute zero
  always_comb begin
    idx = '0;
    for (int k = 0; k < DN; k++)
      if (cnt == CW'(k))
        idx = seq_q[k*DW_sequence +: DW_sequence];
    sample = '0;
    for (int k = 0; k < DN; k++)
      if (idx == DW_sequence'(k))
        sample = data_q[k*DW +: DW];
  end

  // acc doubles as dividend shifter and quotient collector
  always_comb begin
    rem_sh = {rem, acc[ACCW-1]};
    if (rem_sh >= DIVISOR) begin
      rem_nx = ACCW'(rem_sh - DIVISOR);
      q_nx   = {acc[ACCW-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[ACCW-1:0];
      q_nx   = {acc[ACCW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    acc_done = 1'b0;
    div_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (sort_finish) begin
          start    = 1'b1;
          state_nx = ACC;
        end
      end
      ACC: begin
        if (cnt == LAST) begin
          acc_done = 1'b1;
          state_nx = DIV;
        end
      end
      DIV: begin
        if (dcnt == DLAST) begin
          div_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      seq_q      <= '0;
      cnt        <= '0;
      dcnt       <= '0;
      acc        <= '0;
      rem        <= '0;
      mean_out   <= '0;
      mean_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mean_valid <= div_done;
      busy       <= (state_nx != IDLE);
      overrun    <= sort_finish && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            data_q <= data_unsort;
            seq_q  <= sequence_sorted;
            acc    <= ROUND;
            cnt    <= FIRST;
            rem    <= '0;
            dcnt   <= '0;
          end
        end
        ACC: begin
          acc <= acc + ACCW'(sample);
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc  <= q_nx;
          rem  <= rem_nx;
          dcnt <= dcnt + 1'b1;
          if (acc_done == 1'b0 && div_done)
            mean_out <= q_nx[DW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Bench for alpha_trim_mean: directed table, corner sequences,
// and random windows checked against a sort-based reference.
module tb_alpha_trim_mean;

  localparam int DN   = 25;
  localparam int DW   = 8;
  localparam int SW   = 5;
  localparam int TRIM = 4;
  localparam int N    = DN - 2*TRIM;
  localparam int LAT  = 30;

  typedef logic [DW*DN-1:0] data_t;
  typedef logic [SW*DN-1:0] seq_t;

  typedef struct {
    data_t d;
    seq_t  s;
    int    exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  sort_finish = 1'b0;
  data_t data_unsort = '0;
  seq_t  sequence_sorted = '0;
  logic [DW-1:0] mean_out;
  logic  mean_valid;
  logic  busy;
  logic  overrun;

  int passed = 0;
  int total  = 0;

  alpha_trim_mean #(
    .DN(DN), .DW(DW), .DW_sequence(SW), .TRIM(TRIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sort_finish(sort_finish),
    .data_unsort(data_unsort),
    .sequence_sorted(sequence_sorted),
    .mean_out(mean_out),
    .mean_valid(mean_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int exp);
    total++;
    if (act != exp)
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else
      passed++;
  endfunction

  // Reference: sort values, keep the middle N, rounded average
  function automatic void build(input int v[DN], output data_t d,
                                output seq_t s, output int e);
    int ix[DN];
    int t;
    int sum;
    for (int i = 0; i < DN; i++) ix[i] = i;
    for (int i = 0; i < DN; i++)
      for (int j = 0; j < DN - 1 - i; j++)
        if (v[ix[j]] > v[ix[j+1]]) begin
          t = ix[j]; ix[j] = ix[j+1]; ix[j+1] = t;
        end
    d = '0;
    s = '0;
    sum = 0;
    for (int i = 0; i < DN; i++) d[i*DW +: DW] = DW'(v[i]);
    for (int k = 0; k < DN; k++) s[k*SW +: SW] = SW'(ix[k]);
    for (int k = TRIM; k < DN - TRIM; k++) sum += v[ix[k]];
    e = (sum + N/2) / N;
  endfunction

  task automatic start_win(input data_t d, input seq_t s);
    sort_finish = 1'b1;
    data_unsort = d;
    sequence_sorted = s;
    @(negedge clk);
    sort_finish = 1'b0;
  endtask

  task automatic wait_valid(input int exp, input int from, input string nm);
    int c;
    int ovr;
    int idle;
    bit got;
    c = from; ovr = 0; idle = 0; got = 0;
    while (!got && c < from + 60) begin
      @(negedge clk);
      c++;
      if (overrun) ovr++;
      if (mean_valid) got = 1;
      else if (!busy) idle++;
    end
    check({nm, " latency"}, got ? c : -1, LAT);
    check({nm, " mean"}, int'(mean_out), exp);
    check({nm, " busy_at_valid"}, int'(busy), 0);
    check({nm, " busy_gap"}, idle, 0);
    check({nm, " overrun"}, ovr, 0);
  endtask

  vec_t vt[4];
  int   v[DN];
  data_t rd;
  seq_t  rs;
  int    re;
  int    cnt_v;
  int    cnt_b;
  int    cnt_o;
  int    k;

  initial begin
    // all 100, identity order
    for (int i = 0; i < DN; i++) begin
      vt[0].d[i*DW +: DW] = 8'd100;
      vt[0].s[i*SW +: SW] = SW'(i);
    end
    vt[0].exp = 100;
    // ramp, kept 4..20 sums to 204
    for (int i = 0; i < DN; i++) begin
      vt[1].d[i*DW +: DW] = DW'(i);
      vt[1].s[i*SW +: SW] = SW'(i);
    end
    vt[1].exp = 12;
    // trim: zeros at 5,10,15,20; 255 at 0..3; 50 elsewhere
    k = 4;
    for (int i = 0; i < DN; i++) begin
      if (i % 5 == 0 && i > 0) begin
        vt[2].d[i*DW +: DW] = 8'd0;
        vt[2].s[(i/5 - 1)*SW +: SW] = SW'(i);
      end else if (i < 4) begin
        vt[2].d[i*DW +: DW] = 8'd255;
        vt[2].s[(21 + i)*SW +: SW] = SW'(i);
      end else begin
        vt[2].d[i*DW +: DW] = 8'd50;
        vt[2].s[k*SW +: SW] = SW'(i);
        k++;
      end
    end
    vt[2].exp = 50;
    // rounding: sixteen 10s and one 19 kept, sum 179
    for (int i = 0; i < DN; i++) begin
      vt[3].d[i*DW +: DW] = (i < 4) ? 8'd0 : (i < 20) ? 8'd10 :
                            (i == 20) ? 8'd19 : 8'd200;
      vt[3].s[i*SW +: SW] = SW'(i);
    end
    vt[3].exp = 11;

    repeat (2) @(negedge clk);
    check("reset mean_out", int'(mean_out), 0);
    check("reset mean_valid", int'(mean_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      start_win(vt[t].d, vt[t].s);
      check($sformatf("vec%0d busy_after_start", t), int'(busy), 1);
      wait_valid(vt[t].exp, 0, $sformatf("vec%0d", t));
      @(negedge clk);
      check($sformatf("vec%0d valid_pulse", t), int'(mean_valid), 0);
      check($sformatf("vec%0d hold", t), int'(mean_out), vt[t].exp);
    end

    // second start while busy
    start_win(vt[1].d, vt[1].s);
    repeat (4) @(negedge clk);
    sort_finish = 1'b1;
    data_unsort = vt[0].d;
    sequence_sorted = vt[0].s;
    @(negedge clk);
    sort_finish = 1'b0;
    check("ovr pulse", int'(overrun), 1);
    check("ovr busy", int'(busy), 1);
    @(negedge clk);
    check("ovr one_cycle", int'(overrun), 0);
    wait_valid(vt[1].exp, 6, "ovr");
    cnt_v = 0;
    repeat (35) begin
      @(negedge clk);
      if (mean_valid) cnt_v++;
    end
    check("ovr extra_valid", cnt_v, 0);

    // reset mid-accumulation
    start_win(vt[0].d, vt[0].s);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mean_out", int'(mean_out), 0);
    check("rst mean_valid", int'(mean_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_v = 0; cnt_b = 0; cnt_o = 0;
    repeat (40) begin
      @(negedge clk);
      if (mean_valid) cnt_v++;
      if (busy) cnt_b++;
      if (overrun) cnt_o++;
    end
    check("rst no_valid", cnt_v, 0);
    check("rst no_busy", cnt_b, 0);
    check("rst no_overrun", cnt_o, 0);
    start_win(vt[3].d, vt[3].s);
    wait_valid(vt[3].exp, 0, "rst restart");

    // random windows, started back-to-back in the valid cycle
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DN; i++)
        v[i] = (t < 2) ? int'($urandom_range(0, 3)) * 85
                       : int'($urandom_range(0, 255));
      build(v, rd, rs, re);
      start_win(rd, rs);
      wait_valid(re, 0, $sformatf("rand%0d", t));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alpha_trim_mean.md
ALPHA_TRIM_MEAN -- requirements
Module: alpha_trim_mean

Interface
REQ-001 SHALL have parameter DN, default 25: number of window samples.
REQ-002 SHALL have parameter DW, default 8: sample width in bits.
REQ-003 SHALL have parameter DW_sequence, default $clog2(DN): width of one index field.
REQ-004 SHALL have parameter TRIM, default 4: samples discarded at each end; legal range 0 <= TRIM, 2*TRIM < DN.
REQ-005 SHALL have derived constants N = DN-2*TRIM (kept count, 17 at defaults) and ACCW = DW+$clog2(DN) (accumulator width, 13 at defaults).
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port sort_finish, input, 1: one-cycle strobe; data_unsort and sequence_sorted are valid in that cycle.
REQ-009 SHALL have port data_unsort, input, DW*DN: window samples; sample i at bits [i*DW +: DW].
REQ-010 SHALL have port sequence_sorted, input, DW_sequence*DN: slot k at [k*DW_sequence +: DW_sequence] holds the original index of the k-th smallest sample (ascending).
REQ-011 SHALL have port mean_out, output, DW: rounded trimmed mean.
REQ-012 SHALL have port mean_valid, output, 1: one-cycle strobe qualifying mean_out.
REQ-013 SHALL have port busy, output, 1: high while a computation is in progress.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when sort_finish is dropped.

Function
REQ-015 SHALL implement states IDLE, ACC, DIV; all outputs registered.
REQ-016 In IDLE, an edge sampling sort_finish=1 SHALL latch both input vectors, load acc = N/2 (integer, rounding offset), set slot counter to TRIM, and enter ACC.
REQ-017 Each ACC edge SHALL add latched sample[latched slot[counter]] to acc and increment the counter.
REQ-018 The edge adding slot DN-1-TRIM SHALL enter DIV, so ACC lasts exactly N edges; slots 0..TRIM-1 and DN-TRIM..DN-1 are never added.
REQ-019 acc SHALL be ACCW bits unsigned; it does not overflow for any legal input.
REQ-020 DIV SHALL compute floor(acc/N) by restoring division, one quotient bit per edge, MSB first, over exactly ACCW edges; N is a constant divisor.
REQ-021 The final DIV edge SHALL load mean_out with the low DW quotient bits, set mean_valid=1 for one cycle, and return to IDLE.
REQ-022 The quotient SHALL always fit in DW bits; no saturation logic.
REQ-023 Latency: mean_valid SHALL be high in the cycle following edge 1+N+ACCW-1 counted from the sampling edge (30 edges after the sampling edge at defaults); throughput one result per N+ACCW+1 cycles.
REQ-024 busy SHALL be 1 in ACC and DIV, 0 in IDLE, including the mean_valid cycle.
REQ-025 sort_finish during ACC or DIV SHALL be ignored with no effect on the computation, and SHALL produce a one-cycle overrun pulse.
REQ-026 sort_finish in the mean_valid cycle (state IDLE) SHALL be accepted as a new start.
REQ-027 mean_out SHALL hold its value until the next mean_valid.
REQ-028 Index fields >= DN in sequence_sorted are illegal input; behaviour is unspecified but SHALL NOT hang the state machine.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, acc=0, counter=0, mean_out=0, mean_valid=0, busy=0, overrun=0, asynchronously and at any point, including mid-ACC or mid-DIV.
REQ-030 After reset release, a computation interrupted by reset SHALL produce no mean_valid.

Verification
REQ-031 All samples 100, identity sequence -> mean_valid 30 cycles after start, mean_out=100.
REQ-032 sample[i]=i, slot k=k -> kept 4..20, sum 204 -> mean_out=12.
REQ-033 Trim check: slots 0-3 index samples of 0, slots 21-24 samples of 255, remaining 17 samples 50 -> mean_out=50.
REQ-034 Rounding: kept samples sixteen of 10 and one of 19 (sum 179) -> mean_out=11 (not 10).
REQ-035 Second sort_finish 5 cycles after the first -> overrun pulses once, busy stays high, single mean_valid with the first window's result.
REQ-036 rst_n low for 2 cycles mid-ACC -> all outputs 0 at once, no mean_valid; a new start afterwards gives the correct result.
